bcd_seg_scan: RTL and testbench

Multiplexed 7-segment display driver downstream of a chain of BCD counter digits. It accepts NDIG packed BCD digits plus per-digit decimal points and time-multiplexes them onto one active-low segment bus with active-low digit anodes. It snapshots the input once per frame so a digit never tears mid-scan. It optionally blanks leading zeros.

---
 rtl/bcd_seg_scan.sv | 115 +++++++++++
 tb/tb_bcd_seg_scan.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/bcd_seg_scan.sv
// Multiplexed active-low 7-segment driver for NDIG packed BCD digits.
// The digits are snapshotted once per frame, and leading zeros can optionally be blanked.
module bcd_seg_scan #(
  parameter int NDIG     = 4,
  parameter int DWL      = 4,
  parameter int PRESCALE = 100000
) (
  input  logic                 CLK,
  input  logic                 CLR_N,
  input  logic                 ENABLE,
  input  logic [NDIG*DWL-1:0]  BCD,
  input  logic [NDIG-1:0]      DP_IN,
  input  logic                 BLANK_LZ,
  output logic [NDIG-1:0]      AN,
  output logic [6:0]           SEG,
  output logic                 DP,
  output logic                 FRAME
);

  localparam int CW = $clog2(PRESCALE);
  localparam int IW = $clog2(NDIG);
  localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NDIG - 1);

  logic [CW-1:0]       cnt;
  logic [IW-1:0]       idx;
  logic [NDIG*DWL-1:0] snap;
  logic [NDIG-1:0]     snap_dp;
  logic                en_d;

  logic                tick;
  logic                start;
  logic [DWL-1:0]      cur_digit;
  logic [6:0]          cur_seg;
  logic [NDIG-1:0]     lz_mask;
  logic                lz_run;
  logic                live_slot;

  assign tick      = ENABLE && (cnt == CNT_LAST);
  assign start     = ENABLE && (!en_d || (tick && (idx == IDX_LAST)));
  assign cur_digit = snap[idx*DWL +: DWL];

  // lz_mask[k] is set when every digit from k upward is zero with no decimal point.
  always_comb begin
    lz_run  = 1'b1;
    lz_mask = '0;
    for (int k = NDIG - 1; k > 0; k--) begin
      lz_run     = lz_run && (snap[k*DWL +: DWL] == '0) && !snap_dp[k];
      lz_mask[k] = lz_run;
    end
  end

  always_comb begin
    cur_seg = 7'b0111111;
    case (cur_digit)
      4'd0: cur_seg = 7'b1000000;
      4'd1: cur_seg = 7'b1111001;
      4'd2: cur_seg = 7'b0100100;
      4'd3: cur_seg = 7'b0110000;
      4'd4: cur_seg = 7'b0011001;
      4'd5: cur_seg = 7'b0010010;
      4'd6: cur_seg = 7'b0000010;
      4'd7: cur_seg = 7'b1111000;
      4'd8: cur_seg = 7'b0000000;
      4'd9: cur_seg = 7'b0010000;
      default: cur_seg = 7'b0111111;
    endcase
  end

  // On the first enabled cycle the snapshot is still stale. The display stays dark in that cycle,
  // so digit 0 first lights with fresh data.
  assign live_slot = ENABLE && en_d && !(BLANK_LZ && lz_mask[idx]);

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      cnt     <= '0;
      idx     <= '0;
      snap    <= '0;
      snap_dp <= '0;
      en_d    <= 1'b0;
      AN      <= '1;
      SEG     <= 7'h7F;
      DP      <= 1'b1;
      FRAME   <= 1'b0;
    end else begin
      en_d  <= ENABLE;
      FRAME <= start;
      if (!ENABLE) begin
        cnt <= '0;
        idx <= '0;
      end else if (start) begin
        snap    <= BCD;
        snap_dp <= DP_IN;
        idx     <= '0;
        cnt     <= '0;
      end else if (tick) begin
        idx <= idx + 1'b1;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end

      if (live_slot) begin
        AN  <= ~(NDIG'(1) << idx);
        SEG <= cur_seg;
        DP  <= ~snap_dp[idx];
      end else begin
        AN  <= '1;
        SEG <= 7'h7F;
        DP  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bcd_seg_scan.sv
// Directed bench for bcd_seg_scan (NDIG=4, PRESCALE=4).
// Expected {FRAME,AN,SEG,DP} words are queued when stimulus is driven and popped once per clock.
module tb_bcd_seg_scan;

  localparam logic [12:0] DARK    = 13'h0FFF;
  localparam logic [12:0] FRAME_W = 13'h1000;

  logic        CLK;
  logic        CLR_N;
  logic        ENABLE;
  logic [15:0] BCD;
  logic [3:0]  DP_IN;
  logic        BLANK_LZ;
  logic [3:0]  AN;
  logic [6:0]  SEG;
  logic        DP;
  logic        FRAME;

  logic [12:0] exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  bcd_seg_scan #(.NDIG(4), .DWL(4), .PRESCALE(4)) dut (
    .CLK(CLK), .CLR_N(CLR_N), .ENABLE(ENABLE), .BCD(BCD), .DP_IN(DP_IN),
    .BLANK_LZ(BLANK_LZ), .AN(AN), .SEG(SEG), .DP(DP), .FRAME(FRAME)
  );

  // Clock and watchdog.
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // Reference tables.
  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  function automatic logic [12:0] slot_word(input logic [15:0] b, input logic [3:0] d,
                                            input logic blz, input int k);
    int         top;
    logic [3:0] an;
    top = 0;
    for (int j = 0; j < 4; j++)
      if (b[j*4 +: 4] != 4'h0 || d[j]) top = j;
    if (blz && k > top) return DARK;
    an    = 4'hF;
    an[k] = 1'b0;
    return {1'b0, an, seg_of(b[k*4 +: 4]), ~d[k]};
  endfunction

  // Driver/scoreboard tasks.
  task automatic push_slots(input logic [15:0] b, input logic [3:0] d, input logic blz,
                            input int n, input logic frame_end);
    logic [12:0] w;
    for (int c = 0; c < n; c++) begin
      w = slot_word(b, d, blz, c / 4);
      if (c == 15 && frame_end) w = w | FRAME_W;
      exp_q.push_back(w);
    end
  endtask

  task automatic compare_one(input string tag);
    logic [12:0] o;
    logic [12:0] e;
    o = {FRAME, AN, SEG, DP};
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $error("FAIL %s: observed %h but expected queue is empty", tag, o);
    end else begin
      e = exp_q.pop_front();
      assert (o === e) else begin
        n_bad++;
        $error("FAIL %s: observed frame=%b an=%b seg=%b dp=%b expected frame=%b an=%b seg=%b dp=%b",
               tag, o[12], o[11:8], o[7:1], o[0], e[12], e[11:8], e[7:1], e[0]);
      end
    end
  endtask

  task automatic check_cycles(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
      compare_one(tag);
    end
  endtask

  task automatic check_now(input logic [12:0] w, input string tag);
    exp_q.push_back(w);
    compare_one(tag);
  endtask

  task automatic run_frame(input logic [15:0] b, input logic [3:0] d, input logic blz,
                           input string tag);
    push_slots(b, d, blz, 16, 1'b1);
    check_cycles(16, tag);
  endtask

  // Directed sequence.
  initial begin
    CLR_N    = 1'b1;
    ENABLE   = 1'b0;
    BCD      = 16'h0000;
    DP_IN    = 4'h0;
    BLANK_LZ = 1'b0;

    #2 CLR_N = 1'b0;
    #1 check_now(DARK, "reset_async");
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check_now(DARK, "reset_held");

    // The first frame after enable has a dark start cycle with FRAME high, then digits 0..3.
    CLR_N  = 1'b1;
    ENABLE = 1'b1;
    BCD    = 16'h1234;
    exp_q.push_back(DARK | FRAME_W);
    push_slots(16'h1234, 4'h0, 1'b0, 16, 1'b1);
    check_cycles(17, "frame1_1234");

    // A BCD change while digit 1 is lit must not affect the current frame.
    push_slots(16'h1234, 4'h0, 1'b0, 16, 1'b1);
    check_cycles(5, "frame2_pre_change");
    BCD = 16'h5678;
    check_cycles(11, "frame2_no_tear");
    run_frame(16'h5678, 4'h0, 1'b0, "frame3_5678");

    // BLANK_LZ is live; the new digits are captured at the next start.
    BCD      = 16'h0040;
    BLANK_LZ = 1'b1;
    run_frame(16'h5678, 4'h0, 1'b1, "frame4_blz_nozero");
    DP_IN = 4'b0100;
    run_frame(16'h0040, 4'h0, 1'b1, "frame5_blank_0040");
    BCD   = 16'h2B0A;
    DP_IN = 4'h0;
    run_frame(16'h0040, 4'b0100, 1'b1, "frame6_dp_stops_blank");
    BCD      = 16'h4321;
    BLANK_LZ = 1'b0;
    run_frame(16'h2B0A, 4'h0, 1'b0, "frame7_dash");

    // Drop ENABLE mid-frame, then re-enable.
    push_slots(16'h4321, 4'h0, 1'b0, 6, 1'b0);
    check_cycles(6, "frame8_partial");
    ENABLE = 1'b0;
    BCD    = 16'h8765;
    repeat (3) exp_q.push_back(DARK);
    check_cycles(3, "disabled_dark");
    ENABLE = 1'b1;
    exp_q.push_back(DARK | FRAME_W);
    push_slots(16'h8765, 4'h0, 1'b0, 16, 1'b1);
    check_cycles(17, "reenable_8765");

    // Pulse CLR_N between clock edges during a scan.
    push_slots(16'h8765, 4'h0, 1'b0, 7, 1'b0);
    check_cycles(7, "pre_clr_scan");
    #1;
    CLR_N = 1'b0;
    BCD   = 16'h9087;
    DP_IN = 4'b0001;
    #1 check_now(DARK, "clr_mid_async");
    #1 CLR_N = 1'b1;
    exp_q.push_back(DARK | FRAME_W);
    push_slots(16'h9087, 4'b0001, 1'b0, 16, 1'b1);
    check_cycles(17, "after_clr_9087");

    n_cmp++;
    assert (exp_q.size() == 0) else begin
      n_bad++;
      $error("FAIL queue_drained: observed %0d leftover entries, expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
